tdm_demux_1_8: RTL and testbench

Receive-side counterpart of the 8:1 select mux. It takes a time-division-multiplexed serial bit stream, one bit per enabled cycle with slot 0 marked by a frame sync, and demultiplexes slots 0..7 back into an 8-bit parallel code. It tracks frame alignment (hunt/lock with flywheel) and sits between a serial link and the 8-bit consumer logic.

---
 rtl/tdm_demux_1_8.sv | 125 ++++++++++++
 tb/tb_tdm_demux_1_8.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1_8.sv
// TDM serial-to-parallel demultiplexer: slots 0..7 of a framed bit stream
// are collected into an 8-bit code, with hunt/lock alignment and flywheel.
module tdm_demux_1_8 #(
    parameter int unsigned SYNC_REQUIRED = 1,
    parameter int unsigned MAX_MISS      = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_d,
    input  logic       i_sync,
    output logic [7:0] o_code,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_locked,
    output logic [2:0] o_sel_code
);

    localparam int unsigned SLOT_W = 3;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned MISS_W = 3;

    localparam logic [0:0] ST_HUNT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = (SYNC_REQUIRED != 0) ? ST_HUNT : ST_RUN;

    localparam logic [SLOT_W-1:0] FIRST_SLOT = SLOT_W'(0);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(CODE_W - 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);

    logic [0:0]        r_state;
    logic [SLOT_W-1:0] r_slot;
    logic [CODE_W-1:0] r_shadow;
    logic [MISS_W-1:0] r_miss;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              r_err;

    logic [0:0]        w_state;
    logic [SLOT_W-1:0] w_slot;
    logic [CODE_W-1:0] w_shadow;
    logic [MISS_W-1:0] w_miss;
    logic [MISS_W-1:0] w_miss_inc;
    logic [CODE_W-1:0] w_code;
    logic              w_valid;
    logic              w_err;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_RESET;
            r_slot   <= FIRST_SLOT;
            r_shadow <= '0;
            r_miss   <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_slot   <= w_slot;
            r_shadow <= w_shadow;
            r_miss   <= w_miss;
            r_code   <= w_code;
            r_valid  <= w_valid;
            r_err    <= w_err;
        end
    end

    // Next-state: alignment tracking, slot capture and frame completion
    always_comb begin
        w_state    = r_state;
        w_slot     = r_slot;
        w_shadow   = r_shadow;
        w_miss     = r_miss;
        w_code     = r_code;
        w_valid    = 1'b0;
        w_err      = 1'b0;
        w_miss_inc = MISS_W'(r_miss + MISS_W'(1));

        if (i_en) begin
            if (r_state == ST_HUNT) begin
                if (i_sync) begin
                    w_state  = ST_RUN;
                    w_shadow = {{(CODE_W-1){1'b0}}, i_d};
                    w_slot   = SLOT_W'(1);
                    w_miss   = '0;
                end
            end else begin
                if (i_sync && (r_slot != FIRST_SLOT)) begin
                    // Misaligned marker restarts the frame; wins over completion
                    w_err    = 1'b1;
                    w_shadow = {{(CODE_W-1){1'b0}}, i_d};
                    w_slot   = SLOT_W'(1);
                    w_miss   = '0;
                end else if (r_slot == FIRST_SLOT) begin
                    if (!i_sync && (w_miss_inc >= MISS_LIMIT)) begin
                        w_state  = ST_HUNT;
                        w_slot   = FIRST_SLOT;
                        w_shadow = '0;
                        w_miss   = '0;
                    end else begin
                        w_shadow = {{(CODE_W-1){1'b0}}, i_d};
                        w_slot   = SLOT_W'(1);
                        w_miss   = i_sync ? '0 : w_miss_inc;
                    end
                end else if (r_slot == LAST_SLOT) begin
                    w_code   = {i_d, r_shadow[CODE_W-2:0]};
                    w_valid  = 1'b1;
                    w_shadow = '0;
                    w_slot   = FIRST_SLOT;
                end else begin
                    w_shadow[r_slot] = i_d;
                    w_slot           = SLOT_W'(r_slot + SLOT_W'(1));
                end
            end
        end
    end

    assign o_code     = r_code;
    assign o_valid    = r_valid;
    assign o_err      = r_err;
    assign o_locked   = (r_state == ST_RUN);
    assign o_sel_code = r_slot;

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Bench for tdm_demux_1_8: two instances (sync required / not) fed the same
// stream, checked every cycle against a frame-level reference model.
module tb_tdm_demux_1_8;

    localparam int MAXM = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic en, d, sync;

    logic [7:0] d_code   [2];
    logic       d_valid  [2];
    logic       d_err    [2];
    logic       d_locked [2];
    logic [2:0] d_sel    [2];

    int total = 0;
    int bad   = 0;

    // Reference model: frame position, collected bits, miss tally
    int         m_locked [2];
    int         m_pos    [2];
    int         m_miss   [2];
    int         m_bits   [2][8];
    logic [7:0] e_code   [2];
    bit         e_valid  [2];
    bit         e_err    [2];
    int         sync_req [2] = '{1, 0};

    always #5 clk = ~clk;

    tdm_demux_1_8 #(.SYNC_REQUIRED(1), .MAX_MISS(MAXM)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_d(d), .i_sync(sync),
        .o_code(d_code[0]), .o_valid(d_valid[0]), .o_err(d_err[0]),
        .o_locked(d_locked[0]), .o_sel_code(d_sel[0])
    );

    tdm_demux_1_8 #(.SYNC_REQUIRED(0), .MAX_MISS(MAXM)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_d(d), .i_sync(sync),
        .o_code(d_code[1]), .o_valid(d_valid[1]), .o_err(d_err[1]),
        .o_locked(d_locked[1]), .o_sel_code(d_sel[1])
    );

    task automatic chk(input string name, input int k, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", name, k, got, exp, $time);
        end
    endtask

    task automatic clear_bits(input int k);
        for (int i = 0; i < 8; i++) m_bits[k][i] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = (sync_req[k] == 0) ? 1 : 0;
            m_pos[k]    = 0;
            m_miss[k]   = 0;
            e_code[k]   = 8'h00;
            e_valid[k]  = 1'b0;
            e_err[k]    = 1'b0;
            clear_bits(k);
        end
    endtask

    // Start a fresh frame whose first collected bit is b
    task automatic start_frame(input int k, input bit b);
        clear_bits(k);
        m_bits[k][0] = int'(b);
        m_pos[k]     = 1;
    endtask

    task automatic model_step(input int k, input bit ben, input bit bd, input bit bs);
        int sum;
        e_valid[k] = 1'b0;
        e_err[k]   = 1'b0;
        if (!ben) return;
        if (m_locked[k] == 0) begin
            if (bs) begin
                m_locked[k] = 1;
                m_miss[k]   = 0;
                start_frame(k, bd);
            end
        end else if (bs && m_pos[k] != 0) begin
            e_err[k]  = 1'b1;
            m_miss[k] = 0;
            start_frame(k, bd);
        end else if (m_pos[k] == 0) begin
            if (bs) m_miss[k] = 0;
            else    m_miss[k] = m_miss[k] + 1;
            if (m_miss[k] >= MAXM) begin
                m_locked[k] = 0;
                m_miss[k]   = 0;
                m_pos[k]    = 0;
                clear_bits(k);
            end else begin
                start_frame(k, bd);
            end
        end else begin
            m_bits[k][m_pos[k]] = int'(bd);
            m_pos[k] = m_pos[k] + 1;
            if (m_pos[k] == 8) begin
                sum = 0;
                for (int i = 0; i < 8; i++) sum += m_bits[k][i] * (1 << i);
                e_code[k]  = 8'(sum);
                e_valid[k] = 1'b1;
                m_pos[k]   = 0;
                clear_bits(k);
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("code",   k, int'(d_code[k]),   int'(e_code[k]));
            chk("valid",  k, int'(d_valid[k]),  int'(e_valid[k]));
            chk("err",    k, int'(d_err[k]),    int'(e_err[k]));
            chk("locked", k, int'(d_locked[k]), m_locked[k]);
            chk("sel",    k, int'(d_sel[k]),    m_pos[k]);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input bit ben, input bit bd, input bit bs);
        en = ben; d = bd; sync = bs;
        @(posedge clk);
        model_step(0, ben, bd, bs);
        model_step(1, ben, bd, bs);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_frame(input logic [7:0] code, input bit with_sync, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) step(1'b0, 1'b1, 1'b1);
            step(1'b1, code[i], with_sync && (i == 0));
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        en = 1'b0; d = 1'b0; sync = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        rst_n = 1'b0; en = 1'b0; d = 1'b0; sync = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        chk("pin_rst_lock", 0, int'(d_locked[0]), 0);
        chk("pin_rst_lock", 1, int'(d_locked[1]), 1);
        rst_n = 1'b1;

        // A5 frame, contiguous
        step(1'b1, 1'b1, 1'b1);
        chk("pin_lock_first", 0, int'(d_locked[0]), 1);
        v = 8'hA5;
        for (int i = 1; i < 8; i++) step(1'b1, v[i], 1'b0);
        chk("pin_a5_model", 0, int'(e_code[0]), 'hA5);
        chk("pin_a5_code",  0, int'(d_code[0]), 'hA5);
        chk("pin_a5_valid", 0, int'(d_valid[0]), 1);
        step(1'b0, 1'b0, 1'b0);
        chk("pin_a5_pulse", 0, int'(d_valid[0]), 0);

        // Same frame with idle cycles between bits
        send_frame(8'hA5, 1'b1, 1'b1);
        chk("pin_gap_code",  0, int'(d_code[0]), 'hA5);
        chk("pin_gap_valid", 0, int'(d_valid[0]), 1);

        // Marker at slot 4 restarts the frame
        send_frame(8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0);
        step(1'b1, 1'b0, 1'b1);
        chk("pin_mis_err",   0, int'(d_err[0]), 1);
        chk("pin_mis_valid", 0, int'(d_valid[0]), 0);
        v = 8'h3C;
        for (int i = 1; i < 8; i++) step(1'b1, v[i], 1'b0);
        chk("pin_3c_code", 0, int'(d_code[0]), 'h3C);
        chk("pin_3c_model", 0, int'(e_code[0]), 'h3C);

        // Flywheel then lock loss after two missed markers
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0);
        chk("pin_fly_valid", 0, int'(d_valid[0]), 1);
        chk("pin_fly_code",  0, int'(d_code[0]), 'h34);
        step(1'b1, 1'b1, 1'b0);
        chk("pin_drop_lock", 0, int'(d_locked[0]), 0);
        chk("pin_drop_sel",  0, int'(d_sel[0]), 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        chk("pin_hunt_sel", 0, int'(d_sel[0]), 0);

        // Partial frame interrupted by reset
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
        reset_pulse();
        chk("pin_rst_code", 0, int'(d_code[0]), 0);
        chk("pin_rst_lock2", 0, int'(d_locked[0]), 0);

        // Free-running instance captures without a marker
        send_frame(8'h5A, 1'b0, 1'b0);
        chk("pin_5a_code",  1, int'(d_code[1]), 'h5A);
        chk("pin_5a_valid", 1, int'(d_valid[1]), 1);
        chk("pin_5a_hunt",  0, int'(d_code[0]), 0);
        send_frame(8'h81, 1'b1, 1'b0);
        chk("pin_81_code", 0, int'(d_code[0]), 'h81);

        // Marker landing on slot 7 beats completion
        send_frame(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, i == 0);
        step(1'b1, 1'b1, 1'b1);
        chk("pin_s7_err",   0, int'(d_err[0]), 1);
        chk("pin_s7_valid", 0, int'(d_valid[0]), 0);

        // Randomized traffic, markers biased toward frame boundaries
        for (int n = 0; n < 3000; n++) begin
            bit ren, rd, rs;
            ren = ($urandom_range(0, 3) != 0);
            rd  = 1'($urandom_range(0, 1));
            rs  = ($urandom_range(0, 15) == 0) ||
                  ((m_pos[0] == 0) && ($urandom_range(0, 4) != 0));
            step(ren, rd, rs);
            if ($urandom_range(0, 999) == 0) reset_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
